mem_arbiter: RTL and testbench

- Shares the single SRAM/IO port (the mem2IO interface) between two requesters: instruction fetch (IF, read-only) and the load/store data port (D, read/write).
- Grants one transaction at a time, drives OE/WE/address/write-data for a fixed SRAM latency, captures read data and returns a one-cycle ready pulse to the owner.
- Sits between the CPU core and mem2IO. MMIO addresses (switches/HEX) pass through unchanged.

---
 rtl/mem_arb_pkg.sv | 23 ++
 rtl/mem_arb_pick.sv | 45 ++++
 rtl/mem_arbiter.sv | 159 +++++++++++++++
 tb/tb_mem_arbiter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and constants for the mem2IO port arbiter.
//   state_e      : arbiter FSM states (IDLE / ACCESS / RESP)
//   owner_e      : requester identity (OWN_IF = 0, OWN_D = 1)
//   MMIO_SW_ADDR : switch/HEX MMIO address, handy for benches
// -----------------------------------------------------------------------------
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_e;

    localparam logic [31:0] MMIO_SW_ADDR = 32'hFFFF_FFFF;

endpackage

// File: rtl/mem_arb_pick.sv
// -----------------------------------------------------------------------------
// mem_arb_pick
// Combinational winner select for the mem2IO arbiter.
// Optional macro: MEM_ARB_FAIRNESS_EN
//   defined   : on a collision, grant the requester not granted last
//   undefined : fixed priority, D over IF
// A lone request is always granted to whoever raised it.
// Ports:
//   if_req       in  fetch request
//   d_req        in  data request
//   last_owner   in  owner of the most recent grant
//   grant_valid  out at least one request is pending
//   grant_owner  out selected requester
// -----------------------------------------------------------------------------
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic   if_req,
    input  logic   d_req,
    input  owner_e last_owner,
    output logic   grant_valid,
    output owner_e grant_owner
);

`ifndef MEM_ARB_FAIRNESS_EN
    // Fixed priority ignores history.
    logic unused_last_owner;
    assign unused_last_owner = last_owner;
`endif

    always_comb begin
        grant_valid = if_req | d_req;
        grant_owner = OWN_IF;
        if (if_req && d_req) begin
`ifdef MEM_ARB_FAIRNESS_EN
            grant_owner = (last_owner == OWN_IF) ? OWN_D : OWN_IF;
`else
            grant_owner = OWN_D;
`endif
        end else if (d_req) begin
            grant_owner = OWN_D;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares the single mem2IO port between instruction fetch (IF, read-only) and
// the load/store data port (D). One transaction at a time: grant in IDLE,
// drive OE/WE for MEM_LATENCY cycles in ACCESS, pulse the owner's ready in
// RESP. Addresses are passed through undecoded (MMIO included).
// Optional macro: MEM_ARB_FAIRNESS_EN (round-robin on collisions, see
// mem_arb_pick); default build is fixed priority D over IF.
// Ports:
//   Clk, Reset           clock, async active-low reset
//   if_req/if_addr       fetch request (level) and address
//   if_ready/if_rdata    fetch done pulse, fetch data (held)
//   d_req/d_we/d_addr/d_wdata  data request, store flag, address, store data
//   d_ready/d_rdata      data done pulse, load data (held)
//   mem_addr/mem_OE/mem_WE/mem_wdata/mem_rdata  mem2IO side
//   busy                 FSM not in IDLE
//   owner                0 = IF, 1 = D; current or last grant
// Handshake: a requester holds req high until its ready pulse; a req still
// high when the FSM is back in IDLE is taken as a new transaction. Request
// inputs are only sampled in the grant cycle.
// -----------------------------------------------------------------------------
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_LATENCY = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ready,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ready,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_OE,
    output logic              mem_WE,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              owner
);

    localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    state_e            state_q;
    owner_e            owner_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              txn_we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;
    logic              oe_q;
    logic              we_q;
    logic              if_ready_q;
    logic              d_ready_q;
    logic              busy_q;

    logic              grant_valid_d;
    owner_e            grant_owner_d;

    // owner_q doubles as the last-owner history for round-robin.
    mem_arb_pick u_pick (
        .if_req      (if_req),
        .d_req       (d_req),
        .last_owner  (owner_q),
        .grant_valid (grant_valid_d),
        .grant_owner (grant_owner_d)
    );

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q    <= IDLE;
            owner_q    <= OWN_IF;
            cnt_q      <= '0;
            txn_we_q   <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            oe_q       <= 1'b0;
            we_q       <= 1'b0;
            if_ready_q <= 1'b0;
            d_ready_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            // Ready pulses live for the single RESP cycle only.
            if_ready_q <= 1'b0;
            d_ready_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_valid_d) begin
                        owner_q <= grant_owner_d;
                        cnt_q   <= CNT_W'(MEM_LATENCY - 1);
                        busy_q  <= 1'b1;
                        state_q <= ACCESS;
                        if (grant_owner_d == OWN_D) begin
                            addr_q   <= d_addr;
                            wdata_q  <= d_wdata;
                            txn_we_q <= d_we;
                            oe_q     <= ~d_we;
                            we_q     <= d_we;
                        end else begin
                            // Fetch is read-only; mem_wdata keeps its last value.
                            addr_q   <= if_addr;
                            txn_we_q <= 1'b0;
                            oe_q     <= 1'b1;
                            we_q     <= 1'b0;
                        end
                    end
                end
                ACCESS: begin
                    if (cnt_q == '0) begin
                        if (!txn_we_q) begin
                            if (owner_q == OWN_D) d_rdata_q  <= mem_rdata;
                            else                  if_rdata_q <= mem_rdata;
                        end
                        if (owner_q == OWN_D) d_ready_q  <= 1'b1;
                        else                  if_ready_q <= 1'b1;
                        oe_q    <= 1'b0;
                        we_q    <= 1'b0;
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                RESP: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    oe_q    <= 1'b0;
                    we_q    <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_OE    = oe_q;
    assign mem_WE    = we_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign if_ready  = if_ready_q;
    assign d_ready   = d_ready_q;
    assign busy      = busy_q;
    assign owner     = owner_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int L = 2;

  // ---------------- clock / reset ----------------
  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_ready;
  logic [31:0] if_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        d_ready;
  logic [31:0] d_rdata;
  logic [31:0] mem_addr;
  logic        mem_OE;
  logic        mem_WE;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        busy;
  logic        owner;

  always #5 Clk = ~Clk;

  mem_arbiter #(.MEM_LATENCY(L), .ADDR_W(32), .DATA_W(32)) dut (
    .Clk(Clk), .Reset(Reset),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_OE(mem_OE), .mem_WE(mem_WE),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .owner(owner)
  );

  // ---------------- scoreboard / reference model ----------------
  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_q[$];     // expected load data, in completion order
  bit          last_own;     // 0 = IF, 1 = D: who was granted last
  logic [31:0] m_if_rdata;   // data the fetch port should be holding
  logic [31:0] m_d_rdata;    // data the data port should be holding

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    last_own   = 1'b0;
    m_if_rdata = '0;
    m_d_rdata  = '0;
    exp_q.delete();
  endtask

  // Winner of a request pattern, from the arbitration rules.
  function automatic bit model_pick(input bit ir, input bit dr);
    if (ir && dr) begin
`ifdef MEM_ARB_FAIRNESS_EN
      return !last_own;
`else
      return 1'b1;
`endif
    end
    return dr;
  endfunction

  // ---------------- driver tasks ----------------
  // Caller has set up requests; this waits for the grant edge and follows the
  // expected transaction for L+2 cycles (L access, 1 resp, 1 idle).
  task automatic serve(input bit own, input bit we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] rdata, input bit drop);
    bit eff_we;
    eff_we = own & we;
    mem_rdata = rdata;
    if (!eff_we) exp_q.push_back(rdata);
    @(posedge Clk); #1;
    if (drop) begin
      if (own) d_req = 1'b0; else if_req = 1'b0;
    end
    for (int k = 1; k <= L + 2; k++) begin
      @(negedge Clk);
      if (k <= L) begin
        check("acc_busy", busy, 1);
        check("acc_owner", owner, own);
        check("acc_oe", mem_OE, !eff_we);
        check("acc_we", mem_WE, eff_we);
        check("acc_addr", mem_addr, addr);
        if (eff_we) check("acc_wdata", mem_wdata, wdata);
        check("acc_if_ready", if_ready, 0);
        check("acc_d_ready", d_ready, 0);
      end else if (k == L + 1) begin
        check("resp_busy", busy, 1);
        check("resp_oe_we", {mem_OE, mem_WE}, 0);
        check("resp_if_ready", if_ready, !own);
        check("resp_d_ready", d_ready, own);
        if (!eff_we) begin
          if (own) m_d_rdata = exp_q.pop_front();
          else     m_if_rdata = exp_q.pop_front();
        end
        check("resp_if_rdata", if_rdata, m_if_rdata);
        check("resp_d_rdata", d_rdata, m_d_rdata);
        last_own = own;
      end else begin
        check("idle_busy", busy, 0);
        check("idle_ready", {if_ready, d_ready}, 0);
        check("idle_oe_we", {mem_OE, mem_WE}, 0);
        check("idle_addr_hold", mem_addr, addr);
      end
    end
  endtask

  // One request pattern: winner first, then the waiting loser (if any).
  task automatic apply_pair(input bit ir, input bit dr, input bit dwe,
                            input logic [31:0] ia, input logic [31:0] da, input logic [31:0] dwd,
                            input logic [31:0] ird, input logic [31:0] drd, input bit first_d);
    if_req = ir; d_req = dr; if_addr = ia; d_addr = da; d_we = dwe; d_wdata = dwd;
    if (first_d) serve(1'b1, dwe, da, dwd, drd, 1'b1);
    else         serve(1'b0, 1'b0, ia, dwd, ird, 1'b1);
    if (ir && dr) begin
      if (first_d) serve(1'b0, 1'b0, ia, dwd, ird, 1'b1);
      else         serve(1'b1, dwe, da, dwd, drd, 1'b1);
    end
  endtask

  task automatic check_all_zero(input string nm);
    check({nm, "_oe_we"}, {mem_OE, mem_WE}, 0);
    check({nm, "_busy"}, busy, 0);
    check({nm, "_owner"}, owner, 0);
    check({nm, "_ready"}, {if_ready, d_ready}, 0);
    check({nm, "_addr"}, mem_addr, 0);
    check({nm, "_wdata"}, mem_wdata, 0);
    check({nm, "_if_rdata"}, if_rdata, 0);
    check({nm, "_d_rdata"}, d_rdata, 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit          ir;
    bit          dr;
    bit          dwe;
    logic [31:0] ia;
    logic [31:0] da;
    logic [31:0] dwd;
    logic [31:0] ird;
    logic [31:0] drd;
    bit          first_d;
  } vec_t;

  vec_t vecs[4];

  initial begin
    bit ir, dr, fd;
    model_reset();

    // reset state
    #12;
    @(negedge Clk);
    check_all_zero("reset");
    Reset = 1'b1;
    @(negedge Clk);
    check_all_zero("post_reset");

    // IF read; D store; collision; D load from the MMIO switch address
    vecs[0] = '{1, 0, 0, 32'h100, 32'h0,   32'h0,        32'hDEADBEEF, 32'h0,        0};
    vecs[1] = '{0, 1, 1, 32'h0,   32'h200, 32'h12345678, 32'h0,        32'h0,        1};
`ifdef MEM_ARB_FAIRNESS_EN
    vecs[2] = '{1, 1, 0, 32'h140, 32'h240, 32'hCAFE0000, 32'h11110000, 32'h22220000, 0};
`else
    vecs[2] = '{1, 1, 0, 32'h140, 32'h240, 32'hCAFE0000, 32'h11110000, 32'h22220000, 1};
`endif
    vecs[3] = '{0, 1, 0, 32'h0,   MMIO_SW_ADDR, 32'h0,   32'h0,        32'h000002A5, 1};
    for (int i = 0; i < 4; i++)
      apply_pair(vecs[i].ir, vecs[i].dr, vecs[i].dwe, vecs[i].ia, vecs[i].da,
                 vecs[i].dwd, vecs[i].ird, vecs[i].drd, vecs[i].first_d);

    // IF request held across two transactions: back-to-back grants
    if_req = 1'b1; d_req = 1'b0; if_addr = 32'h400;
    serve(1'b0, 1'b0, 32'h400, 32'h0, 32'hA1A1A1A1, 1'b0);
    if_addr = 32'h404;
    serve(1'b0, 1'b0, 32'h404, 32'h0, 32'hA2A2A2A2, 1'b1);

    // reset in the middle of an access
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300; mem_rdata = 32'h55;
    @(posedge Clk); #1 d_req = 1'b0;
    @(negedge Clk);
    check("mid_oe_before", mem_OE, 1);
    #2 Reset = 1'b0;
    #1;
    check("async_oe", mem_OE, 0);
    check("async_we", mem_WE, 0);
    check("async_busy", busy, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge Clk);
      check("rst_no_ready", {if_ready, d_ready}, 0);
    end
    Reset = 1'b1;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      @(negedge Clk);
      check_all_zero("after_rst");
    end

    // two collisions in a row from reset: D, IF, D, IF
    apply_pair(1, 1, 0, 32'h500, 32'h600, 32'h0, 32'hB0B0B0B0, 32'hC0C0C0C0, 1);
    apply_pair(1, 1, 1, 32'h504, 32'h604, 32'h77778888, 32'hB1B1B1B1, 32'h0, 1);

    // randomized patterns against the model
    for (int i = 0; i < 40; i++) begin
      do begin
        ir = 1'($urandom_range(0, 1));
        dr = 1'($urandom_range(0, 1));
      end while (!ir && !dr);
      fd = model_pick(ir, dr);
      apply_pair(ir, dr, 1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
                 $urandom, $urandom, fd);
    end

    // ---------------- report ----------------
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL exp_q_drain: got %0d left expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
